// File: rtl/dp_pkg.sv
// Shared constants, ALU opcode encoding and flag bit positions for the datapath.
package dp_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned RF_AW  = 4;
   localparam int unsigned DM_AW  = 8;

   localparam int unsigned FLG_Z = 2;
   localparam int unsigned FLG_N = 1;
   localparam int unsigned FLG_C = 0;

   typedef enum logic [2:0] {
      ALU_PASS_A = 3'd0,
      ALU_ADD    = 3'd1,
      ALU_SUB    = 3'd2,
      ALU_AND    = 3'd3,
      ALU_OR     = 3'd4,
      ALU_XOR    = 3'd5,
      ALU_NOT    = 3'd6,
      ALU_INC    = 3'd7
   } alu_op_t;

endpackage

// File: rtl/rf_bank.sv
// 16-entry register file: three combinational read ports, one synchronous write port.
module rf_bank
   import dp_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              w_en,
   input  logic [RF_AW-1:0]  w_addr,
   input  logic [DATA_W-1:0] w_data,
   input  logic [RF_AW-1:0]  ra_addr,
   input  logic [RF_AW-1:0]  rb_addr,
   input  logic [RF_AW-1:0]  dbg_addr,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] regs [2**RF_AW];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 2**RF_AW; i++) begin
            regs[i] <= '0;
         end
      end else if (w_en) begin
         regs[w_addr] <= w_data;
      end
   end

   // Reads see the pre-edge contents, so a same-cycle write shows up next cycle.
   assign ra_data  = regs[ra_addr];
   assign rb_data  = regs[rb_addr];
   assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/datapath_unit.sv
// Processor datapath: register file, 256-word data memory, ALU and registered status flags.
module datapath_unit
   import dp_pkg::*;
(
   input  logic              Clk,
   input  logic              Rst,
   input  logic [DM_AW-1:0]  D_addr,
   input  logic              D_wr,
   input  logic              RF_s,
   input  logic [RF_AW-1:0]  RF_W_addr,
   input  logic              RF_W_en,
   input  logic [RF_AW-1:0]  RF_Ra_addr,
   input  logic [RF_AW-1:0]  RF_Rb_addr,
   input  logic [2:0]        Alu_s0,
   input  logic [RF_AW-1:0]  Dbg_addr,
   output logic [DATA_W-1:0] Dbg_data,
   output logic [DATA_W-1:0] Ra_data,
   output logic [DATA_W-1:0] Rb_data,
   output logic [DATA_W-1:0] Alu_out,
   output logic [2:0]        Flags
);

   logic [DATA_W-1:0] mem [2**DM_AW];
   logic [DATA_W-1:0] mq;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W:0]   ext;
   logic              carry;

   assign rf_wdata = RF_s ? mq : Alu_out;

   rf_bank u_rf (
      .clk      (Clk),
      .rst      (Rst),
      .w_en     (RF_W_en),
      .w_addr   (RF_W_addr),
      .w_data   (rf_wdata),
      .ra_addr  (RF_Ra_addr),
      .rb_addr  (RF_Rb_addr),
      .dbg_addr (Dbg_addr),
      .ra_data  (Ra_data),
      .rb_data  (Rb_data),
      .dbg_data (Dbg_data)
   );

   always_comb begin
      Alu_out = '0;
      carry   = 1'b0;
      ext     = '0;
      case (alu_op_t'(Alu_s0))
         ALU_PASS_A: Alu_out = Ra_data;
         ALU_ADD: begin
            ext     = {1'b0, Ra_data} + {1'b0, Rb_data};
            Alu_out = ext[DATA_W-1:0];
            carry   = ext[DATA_W];
         end
         ALU_SUB: begin
            // Top bit of the widened difference is the borrow; C reports its inverse.
            ext     = {1'b0, Ra_data} - {1'b0, Rb_data};
            Alu_out = ext[DATA_W-1:0];
            carry   = ~ext[DATA_W];
         end
         ALU_AND: Alu_out = Ra_data & Rb_data;
         ALU_OR:  Alu_out = Ra_data | Rb_data;
         ALU_XOR: Alu_out = Ra_data ^ Rb_data;
         ALU_NOT: Alu_out = ~Ra_data;
         ALU_INC: begin
            ext     = {1'b0, Ra_data} + {{DATA_W{1'b0}}, 1'b1};
            Alu_out = ext[DATA_W-1:0];
            carry   = ext[DATA_W];
         end
         default: Alu_out = '0;
      endcase
   end

   // Array is deliberately outside the reset branch: contents survive Rst.
   always_ff @(posedge Clk) begin
      if (!Rst && D_wr) begin
         mem[D_addr] <= Ra_data;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         mq <= '0;
      end else begin
         mq <= mem[D_addr];
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         Flags <= '0;
      end else if (RF_W_en && !RF_s) begin
         Flags[FLG_Z] <= (Alu_out == '0);
         Flags[FLG_N] <= Alu_out[DATA_W-1];
         Flags[FLG_C] <= carry;
      end
   end

endmodule

// File: tb/tb_datapath_unit.sv
// Directed bench for datapath_unit; expectations are queued and checked by a negedge monitor.
module tb_datapath_unit;
   import dp_pkg::*;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [7:0]  D_addr;
   logic        D_wr;
   logic        RF_s;
   logic [3:0]  RF_W_addr;
   logic        RF_W_en;
   logic [3:0]  RF_Ra_addr;
   logic [3:0]  RF_Rb_addr;
   logic [2:0]  Alu_s0;
   logic [3:0]  Dbg_addr;
   logic [15:0] Dbg_data;
   logic [15:0] Ra_data;
   logic [15:0] Rb_data;
   logic [15:0] Alu_out;
   logic [2:0]  Flags;

   datapath_unit dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .D_addr     (D_addr),
      .D_wr       (D_wr),
      .RF_s       (RF_s),
      .RF_W_addr  (RF_W_addr),
      .RF_W_en    (RF_W_en),
      .RF_Ra_addr (RF_Ra_addr),
      .RF_Rb_addr (RF_Rb_addr),
      .Alu_s0     (Alu_s0),
      .Dbg_addr   (Dbg_addr),
      .Dbg_data   (Dbg_data),
      .Ra_data    (Ra_data),
      .Rb_data    (Rb_data),
      .Alu_out    (Alu_out),
      .Flags      (Flags)
   );

   always #5 Clk = ~Clk;

   localparam int SEL_DBG = 0;
   localparam int SEL_RA  = 1;
   localparam int SEL_ALU = 2;
   localparam int SEL_FLG = 3;

   typedef struct {
      int          sel;
      logic [15:0] exp;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always @(negedge Clk) begin
      exp_t        e;
      logic [15:0] act;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.sel)
            SEL_DBG: act = Dbg_data;
            SEL_RA:  act = Ra_data;
            SEL_ALU: act = Alu_out;
            default: act = {13'd0, Flags};
         endcase
         checks++;
         if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
      D_wr    = 1'b0;
      RF_W_en = 1'b0;
      RF_s    = 1'b0;
   endtask

   task automatic chk(input int sel, input logic [3:0] addr, input logic [15:0] exp,
                      input string name);
      exp_t e;
      if (sel == SEL_DBG) Dbg_addr = addr;
      e.sel  = sel;
      e.exp  = exp;
      e.name = name;
      sb.push_back(e);
      @(negedge Clk);
      #1;
   endtask

   task automatic alu_set(input alu_op_t op, input logic [3:0] ra, input logic [3:0] rb,
                          input logic [3:0] wa, input logic we);
      Alu_s0     = op;
      RF_Ra_addr = ra;
      RF_Rb_addr = rb;
      RF_W_addr  = wa;
      RF_s       = 1'b0;
      RF_W_en    = we;
   endtask

   task automatic alu_wr(input alu_op_t op, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] wa);
      alu_set(op, ra, rb, wa, 1'b1);
      tick();
   endtask

   // Builds a constant MSB-first by doubling and incrementing.
   task automatic load_const(input logic [3:0] r, input logic [15:0] v);
      alu_wr(ALU_XOR, r, r, r);
      for (int i = 15; i >= 0; i--) begin
         alu_wr(ALU_ADD, r, r, r);
         if (v[i]) alu_wr(ALU_INC, r, r, r);
      end
   endtask

   task automatic store(input logic [3:0] ra, input logic [7:0] addr);
      RF_Ra_addr = ra;
      D_addr     = addr;
      D_wr       = 1'b1;
      tick();
   endtask

   task automatic load(input logic [7:0] addr, input logic [3:0] wa);
      D_addr = addr;
      tick();
      RF_s      = 1'b1;
      RF_W_en   = 1'b1;
      RF_W_addr = wa;
      tick();
   endtask

   initial begin
      Rst = 1'b1; D_addr = '0; D_wr = 1'b0; RF_s = 1'b0; RF_W_addr = '0; RF_W_en = 1'b0;
      RF_Ra_addr = '0; RF_Rb_addr = '0; Alu_s0 = ALU_PASS_A; Dbg_addr = '0;
      tick();
      tick();
      Rst = 1'b0;
      chk(SEL_FLG, 0, 16'h0000, "init_flags");
      alu_set(ALU_NOT, 0, 0, 0, 1'b0);
      chk(SEL_ALU, 0, 16'hFFFF, "init_not_zero");

      // reset clears registers but not memory
      load_const(1, 16'hBEEF);
      store(1, 8'h05);
      load_const(3, 16'h1234);
      chk(SEL_DBG, 3, 16'h1234, "preload_r3");
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      RF_Ra_addr = 3;
      chk(SEL_RA, 0, 16'h0000, "rst_ra_r3");
      chk(SEL_FLG, 0, 16'h0000, "rst_flags");
      chk(SEL_DBG, 1, 16'h0000, "rst_r1");
      load(8'h05, 2);
      chk(SEL_DBG, 2, 16'hBEEF, "mem_survives_rst");
      chk(SEL_FLG, 0, 16'h0000, "load_flags_rst");

      // store then load, flags must hold
      load_const(1, 16'h00A5);
      alu_wr(ALU_NOT, 0, 0, 9);
      chk(SEL_FLG, 0, 16'h0002, "not_flags");
      store(1, 8'h10);
      load(8'h10, 2);
      chk(SEL_DBG, 2, 16'h00A5, "store_load_r2");
      chk(SEL_FLG, 0, 16'h0002, "store_load_flags");

      // add with carry out
      load_const(4, 16'hFFFF);
      load_const(5, 16'h0001);
      alu_set(ALU_ADD, 4, 5, 6, 1'b1);
      chk(SEL_ALU, 0, 16'h0000, "add_alu");
      tick();
      chk(SEL_DBG, 6, 16'h0000, "add_r6");
      chk(SEL_FLG, 0, 16'h0005, "add_flags");

      // subtract with borrow, then the other ops on A=3, B=5
      load_const(4, 16'h0003);
      load_const(5, 16'h0005);
      alu_set(ALU_SUB, 4, 5, 7, 1'b1);
      chk(SEL_ALU, 0, 16'hFFFE, "sub_alu");
      tick();
      chk(SEL_DBG, 7, 16'hFFFE, "sub_r7");
      chk(SEL_FLG, 0, 16'h0002, "sub_flags");
      alu_wr(ALU_SUB, 5, 4, 13);
      chk(SEL_DBG, 13, 16'h0002, "sub_nb_r13");
      chk(SEL_FLG, 0, 16'h0001, "sub_nb_flags");
      alu_set(ALU_PASS_A, 4, 5, 0, 1'b0); chk(SEL_ALU, 0, 16'h0003, "pass_alu");
      alu_set(ALU_AND,    4, 5, 0, 1'b0); chk(SEL_ALU, 0, 16'h0001, "and_alu");
      alu_set(ALU_OR,     4, 5, 0, 1'b0); chk(SEL_ALU, 0, 16'h0007, "or_alu");
      alu_set(ALU_XOR,    4, 5, 0, 1'b0); chk(SEL_ALU, 0, 16'h0006, "xor_alu");
      alu_set(ALU_NOT,    4, 5, 0, 1'b0); chk(SEL_ALU, 0, 16'hFFFC, "not_alu");
      alu_set(ALU_INC,    4, 5, 0, 1'b0); chk(SEL_ALU, 0, 16'h0004, "inc_alu");
      chk(SEL_FLG, 0, 16'h0001, "no_write_flags");

      // register read-during-write
      load_const(8, 16'h1111);
      load_const(9, 16'h2222);
      store(9, 8'h30);
      D_addr = 8'h30;
      tick();
      RF_Ra_addr = 8;
      RF_s       = 1'b1;
      RF_W_en    = 1'b1;
      RF_W_addr  = 8;
      chk(SEL_RA, 0, 16'h1111, "rdw_old");
      tick();
      chk(SEL_RA, 0, 16'h2222, "rdw_new");

      // memory same-address write/read returns the old word
      RF_Ra_addr = 1;
      D_addr     = 8'h30;
      D_wr       = 1'b1;
      tick();
      RF_s = 1'b1; RF_W_en = 1'b1; RF_W_addr = 10;
      tick();
      chk(SEL_DBG, 10, 16'h2222, "mem_rbw_old");
      RF_s = 1'b1; RF_W_en = 1'b1; RF_W_addr = 11;
      tick();
      chk(SEL_DBG, 11, 16'h00A5, "mem_rbw_new");

      // reset coincident with store and register write
      store(8, 8'h20);
      alu_wr(ALU_NOT, 0, 0, 14);
      chk(SEL_FLG, 0, 16'h0002, "pre_rst_flags");
      Rst = 1'b1;
      alu_set(ALU_PASS_A, 1, 1, 12, 1'b1);
      D_addr = 8'h20;
      D_wr   = 1'b1;
      tick();
      Rst = 1'b0;
      chk(SEL_DBG, 1, 16'h0000, "midrst_r1");
      chk(SEL_DBG, 8, 16'h0000, "midrst_r8");
      chk(SEL_DBG, 12, 16'h0000, "midrst_r12");
      chk(SEL_FLG, 0, 16'h0000, "midrst_flags");
      load(8'h20, 2);
      chk(SEL_DBG, 2, 16'h2222, "midrst_mem_kept");

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
